// File: rtl/coverfloat_vector_capture.sv
// Capture stage for floating-point coverage vectors: splits a packed cover vector
// into named fields, registers them, counts accepted vectors and flags bad pad bits.
module coverfloat_vector_capture #(
  parameter int OP_W   = 32,
  parameter int RM_W   = 8,
  parameter int OPND_W = 128,
  parameter int FMT_W  = 8,
  parameter int X_W    = 32,
  parameter int M_W    = 192,
  localparam int VEC_W = OP_W + RM_W + 4*OPND_W + 3*FMT_W + 4 + X_W + M_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              vec_valid,
  input  logic [VEC_W-1:0]  covervector,
  output logic [OP_W-1:0]   op,
  output logic [RM_W-1:0]   rm,
  output logic [OPND_W-1:0] a,
  output logic [OPND_W-1:0] b,
  output logic [OPND_W-1:0] c,
  output logic [FMT_W-1:0]  operandFmt,
  output logic [OPND_W-1:0] result,
  output logic [FMT_W-1:0]  resultFmt,
  output logic [FMT_W-1:0]  exceptionBits,
  output logic              intermS,
  output logic [X_W-1:0]    intermX,
  output logic [M_W-1:0]    intermM,
  output logic              sample,
  output logic              pad_err,
  output logic [31:0]       vectornum
);

  // Field LSB positions, built up from the least-significant field.
  localparam int M_LSB    = 0;
  localparam int X_LSB    = M_LSB + M_W;
  localparam int S_BIT    = X_LSB + X_W;
  localparam int PAD_LSB  = S_BIT + 1;
  localparam int EXC_LSB  = PAD_LSB + 3;
  localparam int RFMT_LSB = EXC_LSB + FMT_W;
  localparam int RES_LSB  = RFMT_LSB + FMT_W;
  localparam int OFMT_LSB = RES_LSB + OPND_W;
  localparam int C_LSB    = OFMT_LSB + FMT_W;
  localparam int B_LSB    = C_LSB + OPND_W;
  localparam int A_LSB    = B_LSB + OPND_W;
  localparam int RM_LSB   = A_LSB + OPND_W;
  localparam int OP_LSB   = RM_LSB + RM_W;

  logic [OP_W-1:0]   op_q,   op_d;
  logic [RM_W-1:0]   rm_q,   rm_d;
  logic [OPND_W-1:0] a_q,    a_d;
  logic [OPND_W-1:0] b_q,    b_d;
  logic [OPND_W-1:0] c_q,    c_d;
  logic [FMT_W-1:0]  ofmt_q, ofmt_d;
  logic [OPND_W-1:0] res_q,  res_d;
  logic [FMT_W-1:0]  rfmt_q, rfmt_d;
  logic [FMT_W-1:0]  exc_q,  exc_d;
  logic              s_q,    s_d;
  logic [X_W-1:0]    x_q,    x_d;
  logic [M_W-1:0]    m_q,    m_d;
  logic              sample_q,    sample_d;
  logic              pad_err_q,   pad_err_d;
  logic [31:0]       vectornum_q, vectornum_d;

  always_comb begin
    op_d        = op_q;
    rm_d        = rm_q;
    a_d         = a_q;
    b_d         = b_q;
    c_d         = c_q;
    ofmt_d      = ofmt_q;
    res_d       = res_q;
    rfmt_d      = rfmt_q;
    exc_d       = exc_q;
    s_d         = s_q;
    x_d         = x_q;
    m_d         = m_q;
    pad_err_d   = pad_err_q;
    sample_d    = 1'b0;
    vectornum_d = vectornum_q;
    if (vec_valid) begin
      op_d        = covervector[OP_LSB   +: OP_W];
      rm_d        = covervector[RM_LSB   +: RM_W];
      a_d         = covervector[A_LSB    +: OPND_W];
      b_d         = covervector[B_LSB    +: OPND_W];
      c_d         = covervector[C_LSB    +: OPND_W];
      ofmt_d      = covervector[OFMT_LSB +: FMT_W];
      res_d       = covervector[RES_LSB  +: OPND_W];
      rfmt_d      = covervector[RFMT_LSB +: FMT_W];
      exc_d       = covervector[EXC_LSB  +: FMT_W];
      s_d         = covervector[S_BIT];
      x_d         = covervector[X_LSB    +: X_W];
      m_d         = covervector[M_LSB    +: M_W];
      pad_err_d   = |covervector[PAD_LSB +: 3];
      sample_d    = 1'b1;
      // Free-running count; wraps silently at 2^32.
      vectornum_d = vectornum_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q        <= '0;
      rm_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      c_q         <= '0;
      ofmt_q      <= '0;
      res_q       <= '0;
      rfmt_q      <= '0;
      exc_q       <= '0;
      s_q         <= 1'b0;
      x_q         <= '0;
      m_q         <= '0;
      sample_q    <= 1'b0;
      pad_err_q   <= 1'b0;
      vectornum_q <= '0;
    end else begin
      op_q        <= op_d;
      rm_q        <= rm_d;
      a_q         <= a_d;
      b_q         <= b_d;
      c_q         <= c_d;
      ofmt_q      <= ofmt_d;
      res_q       <= res_d;
      rfmt_q      <= rfmt_d;
      exc_q       <= exc_d;
      s_q         <= s_d;
      x_q         <= x_d;
      m_q         <= m_d;
      sample_q    <= sample_d;
      pad_err_q   <= pad_err_d;
      vectornum_q <= vectornum_d;
    end
  end

  assign op            = op_q;
  assign rm            = rm_q;
  assign a             = a_q;
  assign b             = b_q;
  assign c             = c_q;
  assign operandFmt    = ofmt_q;
  assign result        = res_q;
  assign resultFmt     = rfmt_q;
  assign exceptionBits = exc_q;
  assign intermS       = s_q;
  assign intermX       = x_q;
  assign intermM       = m_q;
  assign sample        = sample_q;
  assign pad_err       = pad_err_q;
  assign vectornum     = vectornum_q;

endmodule

// File: tb/tb_coverfloat_vector_capture.sv
// Directed bench for coverfloat_vector_capture: a vector-level model is checked
// against the DUT every negedge, plus literal expectations at key points.
module tb_coverfloat_vector_capture;

  localparam int VEC_W = 804;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             vec_valid = 1'b0;
  logic [VEC_W-1:0] covervector = '0;
  logic [31:0]  op;
  logic [7:0]   rm;
  logic [127:0] a, b, c, result;
  logic [7:0]   operandFmt, resultFmt, exceptionBits;
  logic         intermS;
  logic [31:0]  intermX;
  logic [191:0] intermM;
  logic         sample, pad_err;
  logic [31:0]  vectornum;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  coverfloat_vector_capture dut (
    .clk(clk), .rst_n(rst_n), .vec_valid(vec_valid), .covervector(covervector),
    .op(op), .rm(rm), .a(a), .b(b), .c(c), .operandFmt(operandFmt),
    .result(result), .resultFmt(resultFmt), .exceptionBits(exceptionBits),
    .intermS(intermS), .intermX(intermX), .intermM(intermM),
    .sample(sample), .pad_err(pad_err), .vectornum(vectornum)
  );

  // Model: the last captured vector as a whole, plus sample flag and count.
  logic [VEC_W-1:0] m_vec = '0;
  logic             m_sample = 1'b0;
  logic [31:0]      m_cnt = '0;
  bit               m_live = 1'b0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_vec    = '0;
      m_sample = 1'b0;
      m_cnt    = '0;
      m_live   = 1'b1;
    end else if (vec_valid) begin
      m_vec    = covervector;
      m_sample = 1'b1;
      m_cnt    = m_cnt + 32'd1;
    end else begin
      m_sample = 1'b0;
    end
  end

  task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Field positions written straight from the documented slicing table.
  always @(negedge clk) begin
    if (m_live) begin
      chk("op",            192'(op),            192'(m_vec[803:772]));
      chk("rm",            192'(rm),            192'(m_vec[771:764]));
      chk("a",             192'(a),             192'(m_vec[763:636]));
      chk("b",             192'(b),             192'(m_vec[635:508]));
      chk("c",             192'(c),             192'(m_vec[507:380]));
      chk("operandFmt",    192'(operandFmt),    192'(m_vec[379:372]));
      chk("result",        192'(result),        192'(m_vec[371:244]));
      chk("resultFmt",     192'(resultFmt),     192'(m_vec[243:236]));
      chk("exceptionBits", 192'(exceptionBits), 192'(m_vec[235:228]));
      chk("pad_err",       192'(pad_err),       192'(m_vec[227:225] != 3'b000));
      chk("intermS",       192'(intermS),       192'(m_vec[224]));
      chk("intermX",       192'(intermX),       192'(m_vec[223:192]));
      chk("intermM",       192'(intermM),       m_vec[191:0]);
      chk("sample",        192'(sample),        192'(m_sample));
      chk("vectornum",     192'(vectornum),     192'(m_cnt));
    end
  end

  function automatic logic [VEC_W-1:0] mk(
      input logic [31:0] f_op, input logic [7:0] f_rm,
      input logic [127:0] f_a, input logic [127:0] f_b, input logic [127:0] f_c,
      input logic [7:0] f_ofmt, input logic [127:0] f_res, input logic [7:0] f_rfmt,
      input logic [7:0] f_exc, input logic [2:0] f_pad, input logic f_s,
      input logic [31:0] f_x, input logic [191:0] f_m);
    return {f_op, f_rm, f_a, f_b, f_c, f_ofmt, f_res, f_rfmt, f_exc, f_pad, f_s, f_x, f_m};
  endfunction

  // Drive one cycle of inputs at negedge; return 1 time unit after the next posedge.
  task automatic step(input logic r, input logic v, input logic [VEC_W-1:0] vec);
    @(negedge clk);
    rst_n       = r;
    vec_valid   = v;
    covervector = vec;
    @(posedge clk);
    #1;
  endtask

  logic [VEC_W-1:0] v1, v2, vb;
  logic [191:0]     m_top2;
  int               pulses;

  initial begin
    m_top2 = {2'b11, 190'd0};
    v1 = mk(32'h0000_0011, 8'h02, 128'h3F80_0000, 128'h4000_0000, 128'h0,
            8'h01, 128'h4040_0000, 8'h01, 8'h01, 3'b000, 1'b1, 32'h0000_0080, m_top2);

    // Reset dominates an all-ones valid vector.
    step(1'b0, 1'b1, '1);
    step(1'b0, 1'b1, '1);
    chk("rst_vectornum", 192'(vectornum), 192'd0);
    chk("rst_sample",    192'(sample),    192'd0);
    chk("rst_op",        192'(op),        192'd0);
    chk("rst_intermM",   192'(intermM),   192'd0);

    // Field mapping.
    step(1'b1, 1'b1, v1);
    chk("map_op",        192'(op),        192'h11);
    chk("map_a",         192'(a),         192'h3F80_0000);
    chk("map_result",    192'(result),    192'h4040_0000);
    chk("map_intermX",   192'(intermX),   192'h80);
    chk("map_intermM",   intermM,         m_top2);
    chk("map_intermS",   192'(intermS),   192'd1);
    chk("map_sample",    192'(sample),    192'd1);
    chk("map_pad_err",   192'(pad_err),   192'd0);
    chk("map_vectornum", 192'(vectornum), 192'd1);
    step(1'b1, 1'b0, '0);
    chk("map_sample_drop", 192'(sample),  192'd0);
    chk("map_hold_op",     192'(op),      192'h11);

    // Pad flag, then clean vector clears it.
    v2 = v1;
    v2[227:225] = 3'b101;
    step(1'b1, 1'b1, v2);
    chk("pad_err_set",  192'(pad_err), 192'd1);
    chk("pad_intermS",  192'(intermS), 192'd1);
    step(1'b1, 1'b1, v1);
    chk("pad_err_clr",  192'(pad_err), 192'd0);
    chk("pad_count",    192'(vectornum), 192'd3);

    // Back-to-back then idle, from a fresh count.
    step(1'b0, 1'b0, '0);
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      vb = mk(32'h100 + 32'(i), 8'(i), 128'(i * 7), 128'(i * 11), 128'(i * 13),
              8'(i), 128'hABCD_0000 + 128'(i), 8'(i + 1), 8'(i + 2), 3'(i & 1),
              i[0], 32'hF000_0000 | 32'(i), 192'(i) << 100);
      if (i < 5) step(1'b1, 1'b1, vb);
      else       step(1'b1, 1'b0, '1);
      if (sample) pulses++;
    end
    chk("b2b_pulses",    192'(pulses),    192'd5);
    chk("b2b_vectornum", 192'(vectornum), 192'd5);
    chk("b2b_hold_op",   192'(op),        192'h104);
    chk("b2b_hold_M",    intermM,         192'(4) << 100);

    // Fast-forward the count to near its limit, then wrap.
    @(negedge clk);
    vec_valid = 1'b0;
    force dut.vectornum_q = 32'hFFFF_FFFE;
    m_cnt = 32'hFFFF_FFFE;
    #1;
    release dut.vectornum_q;
    step(1'b1, 1'b1, v2);
    chk("wrap_max",  192'(vectornum), 192'hFFFF_FFFF);
    step(1'b1, 1'b1, v1);
    chk("wrap_zero", 192'(vectornum), 192'd0);
    chk("wrap_sample", 192'(sample),  192'd1);

    // Mid-stream reset drops the presented vector.
    step(1'b0, 1'b1, v2);
    chk("midrst_vectornum", 192'(vectornum), 192'd0);
    chk("midrst_op",        192'(op),        192'd0);
    chk("midrst_pad_err",   192'(pad_err),   192'd0);
    chk("midrst_sample",    192'(sample),    192'd0);
    step(1'b1, 1'b1, v1);
    chk("post_rst_vectornum", 192'(vectornum), 192'd1);
    chk("post_rst_op",        192'(op),        192'h11);
    step(1'b1, 1'b0, '0);

    @(negedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
